// File: rtl/i2c_slave_read_byte.sv
// ---------------------------------------------------------------------------
// i2c_slave_read_byte
//   Receives one 8-bit byte (MSB first) from an I2C master. The master drives
//   both scl and sda; this block only observes them. A reception is started
//   by a one-cycle enable pulse while scl is low. Eight scl rising edges
//   sample the data bits. The following scl falling edge completes the byte.
//   A START or STOP condition seen mid-byte aborts the reception.
//
// Ports
//   clock     in   system clock, rising-edge active
//   reset_n   in   asynchronous active-low reset
//   enable    in   start request (one-cycle pulse, scl low)
//   scl       in   I2C clock from master
//   sda       in   I2C data from master (never driven here)
//   data_out  out  [7:0] last completely received byte
//   finish    out  one-cycle pulse, byte complete
//   error     out  one-cycle pulse, START/STOP detected mid-byte
//   busy      out  high while a reception is in progress
//
// Build option
//   I2C_SLAVE_READ_FILTER_EN : when defined, scl/sda pass through a 2-flop
//   synchronizer followed by a 3-sample stability filter (4-clock lag,
//   glitches of up to 2 clocks rejected). When undefined, the pins are used
//   directly.
// ---------------------------------------------------------------------------
module i2c_slave_read_byte (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       scl,
  input  logic       sda,
  output logic [7:0] data_out,
  output logic       finish,
  output logic       error,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RECEIVE   = 2'd1;
  localparam logic [1:0] ST_WAIT_FALL = 2'd2;

  logic scl_i;
  logic sda_i;

`ifdef I2C_SLAVE_READ_FILTER_EN
  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic [1:0] scl_hist_q;
  logic [1:0] sda_hist_q;
  logic       scl_filt_q;
  logic       sda_filt_q;

  // The filtered level follows the synchronized input only once three
  // consecutive samples agree; otherwise the previously held level is kept.
  function automatic logic stable_level(input logic       cur,
                                        input logic [1:0] hist,
                                        input logic       held);
    logic res;
    if ((cur == hist[0]) && (cur == hist[1])) begin
      res = cur;
    end else begin
      res = held;
    end
    return res;
  endfunction

  assign scl_i = stable_level(scl_sync_q[1], scl_hist_q, scl_filt_q);
  assign sda_i = stable_level(sda_sync_q[1], sda_hist_q, sda_filt_q);

  // Synchronizer chain, sample history and held filter level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= scl_i;
      sda_filt_q <= sda_i;
    end
  end
`else
  assign scl_i = scl;
  assign sda_i = sda;
`endif

  logic [1:0] state_q,    state_d;
  logic [3:0] cnt_q,      cnt_d;
  logic [7:0] shift_q,    shift_d;
  logic [7:0] data_q,     data_d;
  logic       finish_q,   finish_d;
  logic       error_q,    error_d;
  logic       scl_last_q;
  logic       sda_last_q;

  logic rise_s;
  logic fall_s;
  logic start_s;
  logic stop_s;

  assign rise_s  = !scl_last_q && scl_i;
  assign fall_s  = scl_last_q && !scl_i;
  assign start_s = scl_i && scl_last_q && sda_last_q && !sda_i;
  assign stop_s  = scl_i && scl_last_q && !sda_last_q && sda_i;

  // Next-state logic; bus conditions take priority over clock edges.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    finish_d = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !scl_i) begin
          state_d = ST_RECEIVE;
          cnt_d   = 4'd0;
          shift_d = 8'h00;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECEIVE: begin
        if (start_s || stop_s) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (rise_s) begin
          shift_d = {shift_q[6:0], sda_i};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = ST_WAIT_FALL;
          end else begin
            state_d = ST_RECEIVE;
          end
        end else begin
          state_d = ST_RECEIVE;
        end
      end
      ST_WAIT_FALL: begin
        if (start_s || stop_s) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (fall_s) begin
          state_d  = ST_IDLE;
          data_d   = shift_q;
          finish_d = 1'b1;
        end else begin
          state_d = ST_WAIT_FALL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      finish_q   <= 1'b0;
      error_q    <= 1'b0;
      scl_last_q <= 1'b1;
      sda_last_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      finish_q   <= finish_d;
      error_q    <= error_d;
      scl_last_q <= scl_i;
      sda_last_q <= sda_i;
    end
  end

  assign data_out = data_q;
  assign finish   = finish_q;
  assign error    = error_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
